// File: rtl/store_queue_pkg.sv
// Shared types for the store queue and the AGU stage that feeds it.
// Widths here must match the parameters store_queue is elaborated with.
package store_queue_pkg;

    localparam int unsigned SQ_ADDR_W = 32;
    localparam int unsigned SQ_DATA_W = 32;
    localparam int unsigned SQ_SQN_W  = 7;
    localparam int unsigned SQ_MASK_W = SQ_DATA_W / 8;

    typedef logic [SQ_SQN_W-1:0] SqN_t;

    typedef struct packed {
        logic                 valid;
        logic                 committed;
        logic                 except;
        logic [SQ_ADDR_W-1:0] addr;
        logic [SQ_DATA_W-1:0] data;
        logic [SQ_MASK_W-1:0] wmask;
        SqN_t                 sqn;
    } sq_entry_t;

    // Flag encoding of an AGU op as seen by the queue
    typedef enum logic [1:0] {
        SQ_OP_STORE = 2'b00,
        SQ_OP_NOMEM = 2'b01,
        SQ_OP_FAULT = 2'b10
    } sq_op_kind_t;

    // a is older than b when (a - b) is negative in SQN_W-bit arithmetic
    function automatic logic sqn_older(input SqN_t a, input SqN_t b);
        SqN_t diff;
        diff = a - b;
        return diff[SQ_SQN_W-1];
    endfunction

    function automatic sq_op_kind_t sq_op_kind(input logic except,
                                               input logic [SQ_MASK_W-1:0] wmask);
        if (except)
            return SQ_OP_FAULT;
        else if (wmask == '0)
            return SQ_OP_NOMEM;
        else
            return SQ_OP_STORE;
    endfunction

endpackage

// File: rtl/sq_conflict_check.sv
// One entry's contribution to the load-ordering conflict check.
module sq_conflict_check
    import store_queue_pkg::*;
(
    input  logic                 valid,
    input  logic                 except,
    input  logic [SQ_MASK_W-1:0] wmask,
    input  logic [SQ_ADDR_W-1:0] addr,
    input  logic [SQ_SQN_W-1:0]  sqn,
    input  logic [SQ_ADDR_W-1:0] ld_addr,
    input  logic [SQ_SQN_W-1:0]  ld_sqn,
    output logic                 hit
);

    always_comb begin
        hit = valid && !except && (wmask != '0) && sqn_older(sqn, ld_sqn)
              && (addr[SQ_ADDR_W-1:2] == ld_addr[SQ_ADDR_W-1:2]);
    end

endmodule

// File: rtl/store_queue.sv
// Sqn-indexed store queue: holds AGU stores until commit, drains them to
// memory in program order, squashes on mispredict, flags load conflicts.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int unsigned NUM_ENTRIES = 8,
    parameter int unsigned ADDR_W      = SQ_ADDR_W,
    parameter int unsigned DATA_W      = SQ_DATA_W,
    parameter int unsigned SQN_W       = SQ_SQN_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   in_addr,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [DATA_W/8-1:0] in_wmask,
    input  logic                in_except,
    input  logic [SQN_W-1:0]    in_sqn,
    input  logic                br_valid,
    input  logic [SQN_W-1:0]    br_sqn,
    input  logic                comm_valid,
    input  logic [SQN_W-1:0]    comm_sqn,
    output logic                mem_valid,
    input  logic                mem_ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [SQN_W-1:0]    ld_sqn,
    output logic                ld_conflict,
    output logic                empty
);

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    sq_entry_t        q [NUM_ENTRIES];
    SqN_t             head_sqn;
    logic [IDX_W-1:0] in_idx;
    logic [IDX_W-1:0] head_idx;
    sq_entry_t        h;
    logic             eligible;
    logic             drain;
    logic             write_en;
    sq_op_kind_t      head_kind;
    logic [NUM_ENTRIES-1:0] hits;

    assign in_idx   = in_sqn[IDX_W-1:0];
    assign head_idx = head_sqn[IDX_W-1:0];
    assign h        = q[head_idx];

    always_comb begin
        in_ready  = !q[in_idx].valid;
        write_en  = in_valid && in_ready && !(br_valid && sqn_older(br_sqn, in_sqn));
        eligible  = h.valid && h.committed && (h.sqn == head_sqn);
        head_kind = sq_op_kind(h.except, h.wmask);
        mem_valid = eligible && (head_kind == SQ_OP_STORE);
        mem_addr  = {h.addr[ADDR_W-1:2], 2'b00};
        mem_data  = h.data;
        mem_wmask = h.wmask;
        // Non-writing ops retire without a memory handshake
        drain     = eligible && ((head_kind != SQ_OP_STORE) || mem_ready);
    end

    always_comb begin
        empty = 1'b1;
        for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (q[i].valid)
                empty = 1'b0;
        end
    end

    // Later non-blocking writes win: drain overrides commit, write targets a free slot
    always_ff @(posedge clk) begin
        if (rst) begin
            head_sqn <= '0;
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                q[i].valid     <= 1'b0;
                q[i].committed <= 1'b0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
                if (q[i].valid) begin
                    if (br_valid && sqn_older(br_sqn, q[i].sqn)) begin
                        q[i].valid     <= 1'b0;
                        q[i].committed <= 1'b0;
                    end else if (comm_valid && !sqn_older(comm_sqn, q[i].sqn)) begin
                        q[i].committed <= 1'b1;
                    end
                end
            end
            if (drain) begin
                q[head_idx].valid     <= 1'b0;
                q[head_idx].committed <= 1'b0;
                head_sqn              <= head_sqn + 1'b1;
            end
            if (write_en) begin
                q[in_idx] <= '{valid:     1'b1,
                               committed: comm_valid && !sqn_older(comm_sqn, in_sqn),
                               except:    in_except,
                               addr:      in_addr,
                               data:      in_data,
                               wmask:     in_wmask,
                               sqn:       in_sqn};
            end
        end
    end

    for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_conf
        sq_conflict_check u_chk (
            .valid   (q[g].valid),
            .except  (q[g].except),
            .wmask   (q[g].wmask),
            .addr    (q[g].addr),
            .sqn     (q[g].sqn),
            .ld_addr (ld_addr),
            .ld_sqn  (ld_sqn),
            .hit     (hits[g])
        );
    end

    assign ld_conflict = |hits;

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue with a sqn-keyed reference model.
module tb_store_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [31:0] in_data = '0;
    logic [3:0]  in_wmask = '0;
    logic        in_except = 1'b0;
    logic [6:0]  in_sqn = '0;
    logic        br_valid = 1'b0;
    logic [6:0]  br_sqn = '0;
    logic        comm_valid = 1'b0;
    logic [6:0]  comm_sqn = '0;
    logic        mem_valid;
    logic        mem_ready = 1'b1;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [3:0]  mem_wmask;
    logic [31:0] ld_addr = '0;
    logic [6:0]  ld_sqn = '0;
    logic        ld_conflict;
    logic        empty;

    int checks = 0;
    int errors = 0;

    store_queue #(.NUM_ENTRIES(8), .ADDR_W(32), .DATA_W(32), .SQN_W(7)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
        .in_data(in_data), .in_wmask(in_wmask), .in_except(in_except),
        .in_sqn(in_sqn), .br_valid(br_valid), .br_sqn(br_sqn),
        .comm_valid(comm_valid), .comm_sqn(comm_sqn),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_wmask(mem_wmask),
        .ld_addr(ld_addr), .ld_sqn(ld_sqn), .ld_conflict(ld_conflict),
        .empty(empty)
    );

    always #5 clk = ~clk;

    // Reference model: one record per possible sqn, head as a plain integer
    typedef struct {
        bit          v;
        bit          c;
        bit          ex;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } ment_t;

    ment_t       mdl [128];
    int unsigned m_head = 0;
    bit          mdl_ok = 0;
    bit          m_wr, m_dr;
    int unsigned cyc = 0;
    logic [31:0] log_addr [$];
    int unsigned log_cyc [$];
    int unsigned memv_cnt = 0;

    function automatic bit older(int unsigned a, int unsigned b);
        return ((a + 128 - b) % 128) >= 64;
    endfunction

    function automatic bit exp_ready();
        for (int s = 0; s < 128; s++)
            if (mdl[s].v && (s % 8) == (int'(in_sqn) % 8)) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit exp_memv();
        return mdl[m_head].v && mdl[m_head].c && mdl[m_head].m != 4'h0 && !mdl[m_head].ex;
    endfunction

    function automatic bit exp_elig();
        return mdl[m_head].v && mdl[m_head].c;
    endfunction

    function automatic bit exp_conf();
        for (int s = 0; s < 128; s++)
            if (mdl[s].v && !mdl[s].ex && mdl[s].m != 4'h0 && older(s, ld_sqn)
                && (mdl[s].a >> 2) == (ld_addr >> 2)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit exp_empty();
        for (int s = 0; s < 128; s++)
            if (mdl[s].v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            for (int s = 0; s < 128; s++) mdl[s] = '{0, 0, 0, '0, '0, '0};
            m_head = 0;
            mdl_ok = 1;
        end else if (mdl_ok) begin
            m_wr = in_valid && exp_ready() && !(br_valid && older(br_sqn, in_sqn));
            m_dr = exp_elig() && (!exp_memv() || mem_ready);
            for (int s = 0; s < 128; s++) begin
                if (mdl[s].v) begin
                    if (br_valid && older(br_sqn, s)) begin
                        mdl[s].v = 0;
                        mdl[s].c = 0;
                    end else if (comm_valid && !older(comm_sqn, s)) begin
                        mdl[s].c = 1;
                    end
                end
            end
            if (m_dr) begin
                mdl[m_head].v = 0;
                mdl[m_head].c = 0;
                m_head = (m_head + 1) % 128;
            end
            if (m_wr)
                mdl[in_sqn] = '{1, comm_valid && !older(comm_sqn, in_sqn), in_except,
                                in_addr, in_data, in_wmask};
        end
    end

    always @(negedge clk) begin
        if (mdl_ok) begin
            chk("in_ready", in_ready, exp_ready());
            chk("mem_valid", mem_valid, exp_memv());
            chk("ld_conflict", ld_conflict, exp_conf());
            chk("empty", empty, exp_empty());
            if (exp_memv()) begin
                chk("mem_addr", mem_addr, {mdl[m_head].a[31:2], 2'b00});
                chk("mem_data", mem_data, mdl[m_head].d);
                chk("mem_wmask", mem_wmask, mdl[m_head].m);
            end
            if (mem_valid) memv_cnt++;
            if (mem_valid && mem_ready) begin
                log_addr.push_back(mem_addr);
                log_cyc.push_back(cyc);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_except  = 1'b0;
        br_valid   = 1'b0;
        comm_valid = 1'b0;
    endtask

    task automatic put(input int sqn, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] m, input bit ex, input bit cm);
        in_valid   = 1'b1;
        in_sqn     = 7'(sqn);
        in_addr    = a;
        in_data    = d;
        in_wmask   = m;
        in_except  = ex;
        comm_valid = cm;
        comm_sqn   = 7'(sqn);
        step();
    endtask

    task automatic commit(input int sqn);
        comm_valid = 1'b1;
        comm_sqn   = 7'(sqn);
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int base;
        idle(2);
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ld_conflict", ld_conflict, 0);

        // In-order drain of three committed stores
        mem_ready = 1'b1;
        put(0, 32'h100, 32'hA0, 4'hF, 0, 0);
        put(1, 32'h104, 32'hA1, 4'hF, 0, 0);
        put(2, 32'h108, 32'hA2, 4'hF, 0, 0);
        chk("pre_commit_no_mem", mem_valid, 0);
        commit(2);
        idle(5);
        chk("inorder_count", log_addr.size(), 3);
        chk("inorder_a0", log_addr[0], 32'h100);
        chk("inorder_a1", log_addr[1], 32'h104);
        chk("inorder_a2", log_addr[2], 32'h108);
        chk("inorder_back2back", log_cyc[2] - log_cyc[0], 2);
        chk("inorder_empty", empty, 1);

        // Squash younger stores; same-cycle younger write suppressed
        put(3, 32'h110, 32'hB3, 4'hF, 0, 0);
        put(4, 32'h114, 32'hB4, 4'hF, 0, 0);
        put(5, 32'h118, 32'hB5, 4'hF, 0, 0);
        br_valid = 1'b1;
        br_sqn   = 7'd3;
        put(6, 32'h11C, 32'hB6, 4'hF, 0, 0);
        in_sqn = 7'd6;
        #1 chk("squash_write_dropped", in_ready, 1);
        in_sqn = 7'd4;
        #1 chk("squash_slot_freed", in_ready, 1);
        chk("squash_keeps_older", empty, 0);
        commit(3);
        idle(4);
        chk("squash_count", log_addr.size(), 4);
        chk("squash_addr", log_addr[3], 32'h110);
        chk("squash_empty", empty, 1);

        // Backpressure holds payload; unaligned address is word-aligned
        mem_ready = 1'b0;
        put(4, 32'h302, 32'hDEADBEEF, 4'b0110, 0, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", mem_valid, 1);
            chk("bp_addr", mem_addr, 32'h300);
            chk("bp_data", mem_data, 32'hDEADBEEF);
            step();
        end
        mem_ready = 1'b1;
        step();
        chk("bp_released", empty, 1);
        chk("bp_count", log_addr.size(), 5);
        chk("bp_log_addr", log_addr[4], 32'h300);

        // Skip path: no-mask op and faulted op retire without memory traffic
        base = memv_cnt;
        put(5, 32'h500, 32'hC5, 4'h0, 0, 0);
        put(6, 32'h504, 32'hC6, 4'hF, 1, 0);
        commit(6);
        chk("skip_pending2", empty, 0);
        step();
        chk("skip_pending1", empty, 0);
        step();
        chk("skip_empty", empty, 1);
        chk("skip_no_mem", memv_cnt - base, 0);

        // Load conflict against a pending store
        put(7, 32'h200, 32'h11, 4'hF, 0, 0);
        ld_addr = 32'h203; ld_sqn = 7'd8;
        #1 chk("conf_older_same_word", ld_conflict, 1);
        ld_sqn = 7'd7;
        #1 chk("conf_not_older", ld_conflict, 0);
        ld_addr = 32'h204; ld_sqn = 7'd8;
        #1 chk("conf_other_word", ld_conflict, 0);
        ld_addr = '0; ld_sqn = '0;
        commit(7);
        idle(3);
        chk("conf_drained", log_addr[5], 32'h200);

        // Advance head to 126 through same-cycle-committed no-write ops
        for (int s = 8; s < 126; s++) put(s, 32'h0, 32'h0, 4'h0, 0, 1);
        idle(2);
        chk("adv_empty", empty, 1);
        mem_ready = 1'b0;
        put(126, 32'h400, 32'hD0, 4'hF, 0, 0);
        put(127, 32'h404, 32'hD1, 4'hF, 0, 0);
        put(0,   32'h408, 32'hD2, 4'hF, 0, 0);
        put(1,   32'h40C, 32'hD3, 4'hF, 0, 0);
        ld_addr = 32'h404; ld_sqn = 7'd0;
        #1 chk("wrap_127_older_than_0", ld_conflict, 1);
        ld_addr = 32'h408;
        #1 chk("wrap_0_not_older_than_0", ld_conflict, 0);
        ld_addr = 32'h400; ld_sqn = 7'd127;
        #1 chk("wrap_126_older_than_127", ld_conflict, 1);
        ld_addr = '0; ld_sqn = '0;
        mem_ready = 1'b1;
        commit(1);
        idle(6);
        chk("wrap_count", log_addr.size(), 10);
        chk("wrap_a0", log_addr[6], 32'h400);
        chk("wrap_a1", log_addr[7], 32'h404);
        chk("wrap_a2", log_addr[8], 32'h408);
        chk("wrap_a3", log_addr[9], 32'h40C);
        chk("wrap_empty", empty, 1);

        // Reset with a request outstanding drops it; head returns to 0
        mem_ready = 1'b0;
        put(2, 32'h600, 32'hE2, 4'hF, 0, 1);
        chk("mid_pending", mem_valid, 1);
        rst = 1'b1;
        step();
        chk("mid_rst_mem_valid", mem_valid, 0);
        chk("mid_rst_empty", empty, 1);
        rst = 1'b0;
        mem_ready = 1'b1;
        idle(2);
        chk("mid_no_write", log_addr.size(), 10);
        put(0, 32'h700, 32'hF0, 4'hF, 0, 1);
        idle(3);
        chk("post_rst_count", log_addr.size(), 11);
        chk("post_rst_addr", log_addr[10], 32'h700);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
